// File: rtl/led_scan_controller.sv
// Multiplexed scan driver for a common-cathode LED display with anti-ghost blank gaps,
// double-buffered frame content and optional leading-zero suppression.
module led_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 32,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Enable,
  input  logic                    LeadZeroBlank,
  input  logic [5*NUM_DIGITS-1:0] FrameData,
  input  logic                    FrameValid,
  output logic                    FrameReady,
  output logic                    SegA,
  output logic                    SegB,
  output logic                    SegC,
  output logic                    SegD,
  output logic                    SegE,
  output logic                    SegF,
  output logic                    SegG,
  output logic                    DP,
  output logic [NUM_DIGITS-1:0]   nDigit,
  output logic                    ScanWrap
);
  localparam int DIG_W = $clog2(NUM_DIGITS);
  localparam int CYC_W = $clog2(DWELL_CYCLES + BLANK_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                  state, state_nxt;
  logic [DIG_W-1:0]        dig, dig_nxt;
  logic [CYC_W-1:0]        cyc, cyc_nxt;
  logic                    frame_start;
  logic [5*NUM_DIGITS-1:0] shadow, active;
  logic                    full;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    lz_seen;
  logic [4:0]              cur;
  logic [NUM_DIGITS-1:0]   ndigit_nxt;
  logic [6:0]              seg_nxt, seg_q;
  logic                    dp_nxt, wrap_nxt;

  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      4'd10:   return 7'h40;
      default: return 7'h00;
    endcase
  endfunction

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      dig   <= '0;
      cyc   <= '0;
    end else begin
      state <= state_nxt;
      dig   <= dig_nxt;
      cyc   <= cyc_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    dig_nxt     = dig;
    cyc_nxt     = cyc + 1'b1;
    frame_start = 1'b0;
    if (!Enable) begin
      state_nxt = IDLE;
      dig_nxt   = '0;
      cyc_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt   = BLANK;
          dig_nxt     = '0;
          cyc_nxt     = '0;
          frame_start = 1'b1;
        end
        BLANK: begin
          if (cyc == CYC_W'(BLANK_CYCLES - 1)) begin
            state_nxt = SHOW;
            cyc_nxt   = '0;
          end
        end
        SHOW: begin
          if (cyc == CYC_W'(DWELL_CYCLES - 1)) begin
            state_nxt = BLANK;
            cyc_nxt   = '0;
            if (dig == DIG_W'(NUM_DIGITS - 1)) begin
              dig_nxt     = '0;
              frame_start = 1'b1;
            end else begin
              dig_nxt = dig + 1'b1;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          dig_nxt   = '0;
          cyc_nxt   = '0;
        end
      endcase
    end
  end

  // Suppress zeros from the most significant digit down; digit 0 always shows.
  always_comb begin
    lz_mask = '0;
    lz_seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (active[5*i +: 5] != 5'd0) lz_seen = 1'b1;
      lz_mask[i] = LeadZeroBlank && !lz_seen;
    end
  end

  // Outputs are built from the current state so segments and enables move together.
  always_comb begin
    cur        = active[5*dig +: 5];
    ndigit_nxt = '1;
    seg_nxt    = '0;
    dp_nxt     = 1'b0;
    wrap_nxt   = 1'b0;
    if (Enable) begin
      wrap_nxt = (state == BLANK) && (dig == '0) && (cyc == '0);
      if (state == SHOW) begin
        ndigit_nxt[dig] = 1'b0;
        if (!lz_mask[dig]) begin
          seg_nxt = decode(cur[3:0]);
          dp_nxt  = cur[4];
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      nDigit     <= '1;
      seg_q      <= '0;
      DP         <= 1'b0;
      ScanWrap   <= 1'b0;
      FrameReady <= 1'b1;
      full       <= 1'b0;
      active     <= {NUM_DIGITS{5'h0F}};
    end else begin
      nDigit   <= ndigit_nxt;
      seg_q    <= seg_nxt;
      DP       <= dp_nxt;
      ScanWrap <= wrap_nxt;
      if (frame_start && full) begin
        active     <= shadow;
        full       <= 1'b0;
        FrameReady <= 1'b1;
      end else if (FrameValid && FrameReady) begin
        shadow     <= FrameData;
        full       <= 1'b1;
        FrameReady <= 1'b0;
      end
    end
  end

  assign {SegG, SegF, SegE, SegD, SegC, SegB, SegA} = seg_q;

endmodule

// File: tb/tb_led_scan_controller.sv
// Bench for led_scan_controller: directed scenarios plus randomized traffic, every cycle
// compared against a position-in-frame reference model of the display.
module tb_led_scan_controller;
  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int BW    = 2;
  localparam int PER   = BW + DW;
  localparam int FRAME = N * PER;
  localparam int FW    = 5 * N;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          Enable = 1'b0;
  logic          LeadZeroBlank = 1'b0;
  logic          FrameValid = 1'b0;
  logic [FW-1:0] FrameData = '0;
  logic          FrameReady, SegA, SegB, SegC, SegD, SegE, SegF, SegG, DP, ScanWrap;
  logic [N-1:0]  nDigit;
  logic [6:0]    seg;

  always #5 Clock = ~Clock;

  led_scan_controller #(.NUM_DIGITS(N), .DWELL_CYCLES(DW), .BLANK_CYCLES(BW)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .LeadZeroBlank(LeadZeroBlank),
    .FrameData(FrameData), .FrameValid(FrameValid), .FrameReady(FrameReady),
    .SegA(SegA), .SegB(SegB), .SegC(SegC), .SegD(SegD), .SegE(SegE), .SegF(SegF),
    .SegG(SegG), .DP(DP), .nDigit(nDigit), .ScanWrap(ScanWrap)
  );

  assign seg = {SegG, SegF, SegE, SegD, SegC, SegB, SegA};

  int checks = 0;
  int errors = 0;
  int off_left = 0;

  logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

  // Reference model: which frame is visible and where in the frame period the scan is.
  logic [4:0]    m_act [N];
  logic [4:0]    m_sh  [N];
  bit            m_full, m_run, m_acc;
  int            m_pos;
  logic [N-1:0]  e_nd;
  logic [6:0]    e_seg;
  logic          e_dp, e_wrap, e_ready;
  logic [FW-1:0] post_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [4:0] d3, input logic [4:0] d2,
                                        input logic [4:0] d1, input logic [4:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    logic [3:0]    c;
    logic          p;
    for (int i = 0; i < N; i++) begin
      c = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      p = ($urandom_range(0, 7) == 0);
      f[5*i +: 5] = {p, c};
    end
    return f;
  endfunction

  task automatic model_edge();
    bit         fs, old_full, blank;
    int         d, w;
    logic [4:0] cur;
    fs = 0; m_acc = 0; old_full = m_full;
    e_nd = '1; e_seg = '0; e_dp = 1'b0; e_wrap = 1'b0;
    if (Reset) begin
      m_run = 0; m_full = 0;
      foreach (m_act[i]) m_act[i] = 5'h0F;
    end else begin
      if (!Enable) m_run = 0;
      else if (!m_run) begin
        m_run = 1; m_pos = 0; fs = 1;
      end else begin
        d = m_pos / PER;
        w = m_pos % PER;
        e_wrap = (m_pos == 0);
        if (w >= BW) begin
          e_nd[d] = 1'b0;
          blank = LeadZeroBlank && (d > 0);
          for (int j = d; j < N; j++) if (m_act[j] != 5'd0) blank = 0;
          cur = m_act[d];
          if (!blank) begin
            e_seg = lut[cur[3:0]];
            e_dp  = cur[4];
          end
        end
        if (m_pos == FRAME - 1) begin
          m_pos = 0; fs = 1;
        end else m_pos++;
      end
      if (fs && old_full) begin
        foreach (m_act[i]) m_act[i] = m_sh[i];
        m_full = 0;
      end else if (FrameValid && !old_full) begin
        foreach (m_sh[i]) m_sh[i] = FrameData[5*i +: 5];
        m_full = 1; m_acc = 1;
      end
    end
    e_ready = !m_full;
  endtask

  task automatic post(input logic [FW-1:0] f);
    if (!FrameValid) begin
      FrameData  = f;
      FrameValid = 1'b1;
    end else post_q.push_back(f);
  endtask

  task automatic tick();
    @(posedge Clock);
    model_edge();
    #1;
    chk("nDigit", 32'(nDigit), 32'(e_nd));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp", 32'(DP), 32'(e_dp));
    chk("scanwrap", 32'(ScanWrap), 32'(e_wrap));
    chk("frameready", 32'(FrameReady), 32'(e_ready));
    if (m_acc) FrameValid = 1'b0;
    if (!FrameValid) begin
      if (post_q.size() > 0) begin
        FrameData  = post_q.pop_front();
        FrameValid = 1'b1;
      end else FrameData = FW'($urandom);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_lit(input int d, input int budget);
    logic [N-1:0] pat;
    int n;
    pat = '1; pat[d] = 1'b0; n = 0;
    while (nDigit !== pat && n < budget) begin
      tick(); n++;
    end
    chk("wait_lit_timeout", 32'(n < budget), 32'd1);
  endtask

  task automatic wait_posted(input int budget);
    int n;
    n = 0;
    while ((FrameValid || post_q.size() != 0) && n < budget) begin
      tick(); n++;
    end
    chk("post_timeout", 32'(n < budget), 32'd1);
  endtask

  initial begin
    // Reset state
    run(3);
    Reset = 1'b0;
    chk("rst_ndigit", 32'(nDigit), 32'hF);
    chk("rst_seg", 32'(seg), 32'h0);
    chk("rst_ready", 32'(FrameReady), 32'd1);
    chk("rst_wrap", 32'(ScanWrap), 32'd0);

    // Reset mid-scan with a pending frame discards it and blanks the display
    post(mk(5'd9, 5'd9, 5'd9, 5'd9));
    wait_posted(20);
    Enable = 1'b1;
    wait_lit(1, FRAME);
    chk("shown_9", 32'(seg), 32'h6F);
    post(mk(5'd7, 5'd7, 5'd7, 5'd7));
    wait_posted(20);
    run(5);
    chk("pending_ready", 32'(FrameReady), 32'd0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("midrst_ndigit", 32'(nDigit), 32'hF);
    chk("midrst_seg", 32'(seg), 32'h0);
    chk("midrst_ready", 32'(FrameReady), 32'd1);
    run(FRAME);
    wait_lit(2, FRAME);
    chk("midrst_blank", 32'(seg), 32'h0);

    // Basic scan of {4,3,2,1}
    Enable = 1'b0;
    tick();
    post(mk(5'd4, 5'd3, 5'd2, 5'd1));
    wait_posted(20);
    Enable = 1'b1;
    wait_lit(0, FRAME);
    chk("scan_d0", 32'(seg), 32'h06);
    wait_lit(3, FRAME);
    chk("scan_d3", 32'(seg), 32'h66);
    run(2 * FRAME);

    // Tear-free update while digit 2 is lit
    post(mk(5'd8, 5'd8, 5'd8, 5'd8));
    wait_posted(FRAME + 10);
    run(FRAME + 10);
    wait_lit(2, FRAME);
    post(mk(5'd1, 5'd1, 5'd1, 5'd1));
    run(2);
    chk("tear_ready_low", 32'(FrameReady), 32'd0);
    wait_lit(3, FRAME);
    chk("tear_old_d3", 32'(seg), 32'h7F);
    wait_lit(0, FRAME);
    chk("tear_new_d0", 32'(seg), 32'h06);
    chk("tear_ready_high", 32'(FrameReady), 32'd1);

    // Back-to-back posting with FrameValid held high
    post(rand_frame());
    post(rand_frame());
    post(rand_frame());
    wait_posted(5 * FRAME);
    run(FRAME + 10);

    // Leading-zero blanking
    LeadZeroBlank = 1'b1;
    post(mk(5'd0, 5'd0, 5'd5, 5'd0));
    wait_posted(FRAME + 10);
    run(FRAME + 10);
    wait_lit(3, FRAME);
    chk("lzb_d3", 32'(seg), 32'h00);
    wait_lit(1, FRAME);
    chk("lzb_d1", 32'(seg), 32'h6D);
    wait_lit(0, FRAME);
    chk("lzb_d0", 32'(seg), 32'h3F);
    post(mk(5'd0, 5'h10, 5'd5, 5'd0));
    wait_posted(FRAME + 10);
    run(FRAME + 10);
    wait_lit(2, FRAME);
    chk("lzb_dp_seg", 32'(seg), 32'h3F);
    chk("lzb_dp_dp", 32'(DP), 32'd1);
    post(mk(5'd0, 5'd0, 5'd0, 5'd0));
    wait_posted(FRAME + 10);
    run(FRAME + 10);
    wait_lit(1, FRAME);
    chk("lzb_zero_d1", 32'(seg), 32'h00);
    wait_lit(0, FRAME);
    chk("lzb_zero_d0", 32'(seg), 32'h3F);
    LeadZeroBlank = 1'b0;

    // Drop Enable during digit 1, then restart
    post(mk(5'd6, 5'd6, 5'd6, 5'd6));
    wait_posted(FRAME + 10);
    wait_lit(1, FRAME);
    run(5);
    Enable = 1'b0;
    tick();
    chk("drop_ndigit", 32'(nDigit), 32'hF);
    chk("drop_seg", 32'(seg), 32'h0);
    run(3);
    Enable = 1'b1;
    tick();
    tick();
    chk("reen_wrap", 32'(ScanWrap), 32'd1);
    run(BW);
    chk("reen_d0", 32'(nDigit), 32'hE);
    run(FRAME);

    // Randomized traffic
    for (int c = 0; c < 2500; c++) begin
      if (off_left > 0) begin
        off_left--;
        Enable = (off_left == 0);
      end else if ($urandom_range(0, 299) == 0) begin
        Enable   = 1'b0;
        off_left = $urandom_range(1, 6);
      end
      if ($urandom_range(0, 149) == 0) LeadZeroBlank = ~LeadZeroBlank;
      Reset = ($urandom_range(0, 999) == 0);
      if (post_q.size() < 2 && $urandom_range(0, 59) == 0) post(rand_frame());
      tick();
    end
    Reset = 1'b0;
    run(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
